counter_sequencer: RTL and testbench
====================================

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter N, default 4: width of the controlled up/down counter.
REQ-002 Parameter STEP_W, default 8: width of step_count.
REQ-003 clock  in  1  system clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  run request; sampled only in IDLE.
REQ-006 abort  in  1  cancel the run in progress.
REQ-007 mode  in  2  00 up, 01 down, 10 bounce (up to target, then down to start), 11 treated as 00.
REQ-008 start_value, target_value  in  N  run endpoints.
REQ-009 dwell  in  4  idle cycles inserted before each step.
REQ-010 counterN  in  N  counter value feedback; threshold  in  1  counter threshold flag.
REQ-011 enable, dec, load  out  1  counter controls; load_ref_value  out  N  counter load value.
REQ-012 busy  out  1  run in progress; done  out  1  one-cycle completion pulse; hit_threshold  out  1  run ended on threshold.
REQ-013 step_count  out  STEP_W  enable pulses issued in the current or last run.

Function
REQ-014 States: IDLE, LOAD, CHECK, WAIT, STEP, DONE; busy SHALL be 1 in every state except IDLE.
REQ-015 IDLE: start=1 -> latch mode, start_value, target_value, dwell; clear step_count and hit_threshold; clear bounce-leg flag; next state LOAD.
REQ-016 LOAD: load=1, load_ref_value=latched start_value for exactly one cycle; next state CHECK.
REQ-017 CHECK: counterN == current goal -> DONE; otherwise WAIT if latched dwell>0, else STEP.
REQ-018 Goal: mode 00/01 -> target_value; mode 10 -> target_value on first leg, start_value after leg flip.
REQ-019 Mode 10: counterN == target_value in CHECK on first leg -> set leg flag, continue (no DONE); if start_value == target_value, DONE immediately.
REQ-020 WAIT: load dwell counter on entry; stay exactly dwell cycles; then STEP.
REQ-021 STEP: enable=1 for exactly one cycle; dec=1 for mode 01 and bounce second leg, else 0; step_count increments, saturating at all-ones; next state CHECK.
REQ-022 enable, load SHALL never be asserted in the same cycle; dec SHALL be 0 whenever enable=0.
REQ-023 Wrap-around: target behind start in counting direction -> steps continue through modulo-2^N wrap; run length = (target-start) mod 2^N steps (up) or (start-target) mod 2^N (down).
REQ-024 DONE: done=1 for one cycle; next state IDLE; step_count and hit_threshold hold until next start.
REQ-025 abort=1 in any non-IDLE state -> IDLE next cycle, no done pulse, no enable/load that cycle; abort has priority over all transitions.
REQ-026 start while busy SHALL be ignored; start and abort together in IDLE -> abort wins, stay IDLE.
REQ-027 Latched inputs SHALL not change mid-run when module inputs change.

Reset
REQ-028 reset=1 -> state IDLE; enable, dec, load, busy, done, hit_threshold = 0; load_ref_value, step_count = 0.
REQ-029 reset mid-run SHALL abort without done pulse; reset has priority over abort and start.

Configuration
REQ-030 Macro THRESHOLD_STOP_EN defined: threshold=1 sampled in CHECK (goal not met) -> set hit_threshold, go DONE.
REQ-031 Macro THRESHOLD_STOP_EN undefined: threshold ignored; hit_threshold tied 0; port list unchanged.

Verification
REQ-032 N=4, mode 00, start 2, target 6, dwell 0 -> one load cycle with load_ref_value 2, 4 enable pulses dec=0, done once, step_count 4.
REQ-033 Mode 01, start 1, target 14, dwell 2 -> wrap 1->0->15->14, 3 steps dec=1, exactly 2 idle cycles between enable pulses.
REQ-034 Mode 10, start 3, target 5 -> 2 up steps then 2 down steps, counterN returns 3, done, step_count 4.
REQ-035 Mode 00, start 0, target 10, abort asserted after 3rd step -> IDLE next cycle, no done, no further enable; start during run ignored.
REQ-036 THRESHOLD_STOP_EN defined, threshold forced 1 at counterN 4 during run 0->9 -> done, hit_threshold 1, step_count 4; undefined -> runs to 9, hit_threshold 0.
REQ-037 reset asserted mid-WAIT -> all outputs 0 next cycle, busy 0, no done pulse.

Source files
------------

// File: rtl/counter_sequencer.sv
// Sequences an external up/down counter through load/check/wait/step runs; one control pulse per state, done one cycle after goal seen.
// No backpressure: start is taken only in IDLE, abort/reset cancel at once; THRESHOLD_STOP_EN enables early stop on the threshold flag.
module counter_sequencer #(
  parameter int N      = 4,
  parameter int STEP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      start_value,
  input  logic [N-1:0]      target_value,
  input  logic [3:0]        dwell,
  input  logic [N-1:0]      counterN,
  input  logic              threshold,
  output logic              enable,
  output logic              dec,
  output logic              load,
  output logic [N-1:0]      load_ref_value,
  output logic              busy,
  output logic              done,
  output logic              hit_threshold,
  output logic [STEP_W-1:0] step_count
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, WAIT, STEP, DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [N-1:0]        start_q, start_d;
  logic [N-1:0]        target_q, target_d;
  logic [3:0]          dwell_q, dwell_d;
  logic [3:0]          wait_q, wait_d;
  logic                leg_q, leg_d;
  logic                hit_q, hit_d;
  logic [STEP_W-1:0]   step_q, step_d;

  logic                bounce;
  logic                at_goal;
  logic                flip;
  logic                thr_stop;
  logic [N-1:0]        goal;

`ifndef THRESHOLD_STOP_EN
  logic unused_threshold;
  assign unused_threshold = threshold;
`endif

  assign bounce = (mode_q == 2'b10);
  // Bounce returns to the start value once the first leg has reached target.
  assign goal    = (bounce && leg_q) ? start_q : target_q;
  assign at_goal = (counterN == goal);
  assign flip    = bounce && !leg_q && (start_q != target_q);

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    start_d        = start_q;
    target_d       = target_q;
    dwell_d        = dwell_q;
    wait_d         = wait_q;
    leg_d          = leg_q;
    hit_d          = hit_q;
    step_d         = step_q;
    enable         = 1'b0;
    dec            = 1'b0;
    load           = 1'b0;
    load_ref_value = '0;
    done           = 1'b0;
    thr_stop       = 1'b0;
`ifdef THRESHOLD_STOP_EN
    thr_stop = threshold && !at_goal;
`endif

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mode_d   = (mode == 2'b11) ? 2'b00 : mode;
          start_d  = start_value;
          target_d = target_value;
          dwell_d  = dwell;
          step_d   = '0;
          hit_d    = 1'b0;
          leg_d    = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        load           = 1'b1;
        load_ref_value = start_q;
        state_d        = CHECK;
      end
      CHECK: begin
        if (at_goal && !flip) begin
          state_d = DONE;
        end else if (thr_stop) begin
          hit_d   = 1'b1;
          state_d = DONE;
        end else begin
          if (at_goal) leg_d = 1'b1;
          if (dwell_q != 4'd0) begin
            wait_d  = dwell_q - 4'd1;
            state_d = WAIT;
          end else begin
            state_d = STEP;
          end
        end
      end
      WAIT: begin
        if (wait_q == 4'd0) state_d = STEP;
        else                wait_d  = wait_q - 4'd1;
      end
      STEP: begin
        enable  = 1'b1;
        dec     = (mode_q == 2'b01) || (bounce && leg_q);
        if (step_q != '1) step_d = step_q + STEP_W'(1);
        state_d = CHECK;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever the state wanted to do this cycle.
    if (abort && (state_q != IDLE)) begin
      state_d        = IDLE;
      enable         = 1'b0;
      dec            = 1'b0;
      load           = 1'b0;
      load_ref_value = '0;
      done           = 1'b0;
      step_d         = step_q;
      hit_d          = hit_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= 2'b00;
      start_q  <= '0;
      target_q <= '0;
      dwell_q  <= 4'd0;
      wait_q   <= 4'd0;
      leg_q    <= 1'b0;
      hit_q    <= 1'b0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      start_q  <= start_d;
      target_q <= target_d;
      dwell_q  <= dwell_d;
      wait_q   <= wait_d;
      leg_q    <= leg_d;
      hit_q    <= hit_d;
      step_q   <= step_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign step_count    = step_q;
  assign hit_threshold = hit_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: external counter plant, per-cycle expected-trace model, directed and random runs.
module tb_counter_sequencer;
  localparam int N  = 4;
  localparam int SW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [N-1:0]  start_value = '0;
  logic [N-1:0]  target_value = '0;
  logic [3:0]    dwell = 4'd0;
  logic [N-1:0]  counterN;
  logic          threshold;
  logic          enable, dec, load, busy, done, hit_threshold;
  logic [N-1:0]  load_ref_value;
  logic [SW-1:0] step_count;

  logic [N-1:0]  cnt = '0;
  logic          thr_en = 1'b0;
  logic [N-1:0]  thr_val = '0;

  counter_sequencer #(.N(N), .STEP_W(SW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .start_value(start_value), .target_value(target_value), .dwell(dwell),
    .counterN(counterN), .threshold(threshold), .enable(enable), .dec(dec),
    .load(load), .load_ref_value(load_ref_value), .busy(busy), .done(done),
    .hit_threshold(hit_threshold), .step_count(step_count)
  );

  always #5 clock = ~clock;

  // Plant: the controlled up/down counter with its threshold comparator.
  assign counterN  = cnt;
  assign threshold = thr_en && (cnt == thr_val);
  always @(posedge clock) begin
    if (load)        cnt <= load_ref_value;
    else if (enable) cnt <= dec ? cnt - 1'b1 : cnt + 1'b1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Expected output trace: one record per clock cycle of a run.
  typedef struct packed {
    logic          busy, load, enable, dec, done, hit;
    logic [N-1:0]  ldv;
    logic [SW-1:0] sc;
  } rec_t;

  rec_t          q[$];
  logic [SW-1:0] hold_sc = '0;
  logic          hold_hit = 1'b0;
  bit            armed = 1'b0;

`ifdef THRESHOLD_STOP_EN
  function automatic logic [N-1:0] pos_at(input logic [1:0] m, input logic [N-1:0] s,
                                           input logic [N-1:0] t, input int k, input int lg);
    if (m == 2'b00)      return N'(int'(s) + k);
    else if (m == 2'b01) return N'(int'(s) - k);
    else if (k <= lg)    return N'(int'(s) + k);
    else                 return N'(int'(t) - (k - lg));
  endfunction
`endif

  function automatic rec_t mk(input logic b, input logic ld, input logic en, input logic dc,
                              input logic dn, input logic ht, input logic [N-1:0] lv, input int sc);
    rec_t r;
    r.busy = b; r.load = ld; r.enable = en; r.dec = dc; r.done = dn; r.hit = ht;
    r.ldv = lv; r.sc = SW'(sc);
    return r;
  endfunction

  function automatic void build_run(input logic [1:0] m_in, input logic [N-1:0] s,
                                    input logic [N-1:0] t, input logic [3:0] dw,
                                    input logic te, input logic [N-1:0] tv);
    logic [1:0]   m;
    logic [N-1:0] upd, dnd;
    int           steps, lg, stop;
    logic         hit;
    m   = (m_in == 2'b11) ? 2'b00 : m_in;
    upd = t - s;
    dnd = s - t;
    lg  = int'(upd);
    if (m == 2'b00)      steps = int'(upd);
    else if (m == 2'b01) steps = int'(dnd);
    else                 steps = (s == t) ? 0 : 2 * int'(upd);
    stop = steps;
    hit  = 1'b0;
`ifdef THRESHOLD_STOP_EN
    if (te) begin
      for (int k = 0; k < steps; k++) begin
        if (pos_at(m, s, t, k, lg) == tv && !(m == 2'b10 && k == lg)) begin
          stop = k; hit = 1'b1; break;
        end
      end
    end
`else
    if (te && tv == '1) hit = 1'b0;
`endif
    q.push_back(mk(1, 1, 0, 0, 0, 0, s, 0));
    for (int k = 0; k < stop; k++) begin
      q.push_back(mk(1, 0, 0, 0, 0, 0, '0, k));
      for (int w = 0; w < int'(dw); w++) q.push_back(mk(1, 0, 0, 0, 0, 0, '0, k));
      q.push_back(mk(1, 0, 1, (m == 2'b01) || (m == 2'b10 && k >= lg), 0, 0, '0, k));
    end
    q.push_back(mk(1, 0, 0, 0, 0, 0, '0, stop));
    q.push_back(mk(1, 0, 0, 0, 1, hit, '0, stop));
    hold_sc  = SW'(stop);
    hold_hit = hit;
  endfunction

  // Compare process: every cycle after the first reset edge.
  always @(negedge clock) begin
    if (armed) begin
      rec_t e;
      bit   was_idle;
      was_idle = (q.size() == 0);
      if (was_idle) e = mk(0, 0, 0, 0, 0, hold_hit, '0, int'(hold_sc));
      else          e = q.pop_front();
      if (!was_idle && abort && !reset) begin
        e.load = 0; e.enable = 0; e.dec = 0; e.done = 0; e.ldv = '0;
        q.delete();
        hold_sc  = e.sc;
        hold_hit = e.hit;
      end
      chk("busy", busy, e.busy);
      chk("load", load, e.load);
      chk("enable", enable, e.enable);
      chk("dec", dec, e.dec);
      chk("done", done, e.done);
      chk("hit_threshold", hit_threshold, e.hit);
      chk("load_ref_value", load_ref_value, e.ldv);
      chk("step_count", step_count, e.sc);
      if (reset) begin
        q.delete();
        hold_sc  = '0;
        hold_hit = 1'b0;
      end else if (was_idle && start && !abort) begin
        build_run(mode, start_value, target_value, dwell, thr_en, thr_val);
      end
    end
  end

  // Pulse monitor used by the directed literal checks.
  int cyc = 0, en_cnt = 0, dec_cnt = 0, done_cnt = 0, load_cnt = 0, last_en = -1;
  int gap_min = 1000, gap_max = -1;
  logic [N-1:0] ld_val = '0;
  always @(negedge clock) begin
    cyc++;
    if (enable) begin
      if (last_en >= 0) begin
        if (cyc - last_en < gap_min) gap_min = cyc - last_en;
        if (cyc - last_en > gap_max) gap_max = cyc - last_en;
      end
      last_en = cyc;
      en_cnt++;
      if (dec) dec_cnt++;
    end
    if (done) done_cnt++;
    if (load) begin load_cnt++; ld_val = load_ref_value; end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    en_cnt = 0; dec_cnt = 0; done_cnt = 0; load_cnt = 0; last_en = -1;
    gap_min = 1000; gap_max = -1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    tick();
    tick();
  endtask

  int qlen;

  // Launch one run, then scramble the inputs to show they were latched.
  task automatic run_dir(input logic [1:0] m, input logic [N-1:0] s, input logic [N-1:0] t,
                         input logic [3:0] d);
    clear_mon();
    mode = m; start_value = s; target_value = t; dwell = d; start = 1'b1;
    tick();
    start = 1'b0;
    qlen = q.size();
    mode = 2'($urandom); start_value = N'($urandom); target_value = N'($urandom);
    dwell = 4'($urandom);
    wait_done(600);
  endtask

  initial begin
    reset = 1'b1;
    tick();
    armed = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Up, 2 -> 6, no dwell.
    run_dir(2'b00, 4'd2, 4'd6, 4'd0);
    chk("up_trace_len", qlen, 11);
    chk("up_enables", en_cnt, 4);
    chk("up_decs", dec_cnt, 0);
    chk("up_loads", load_cnt, 1);
    chk("up_load_value", ld_val, 2);
    chk("up_dones", done_cnt, 1);
    chk("up_step_count", step_count, 4);
    chk("up_counter", cnt, 6);

    // Down with wrap, 1 -> 14, dwell 2: each gap is one check cycle plus two wait cycles.
    run_dir(2'b01, 4'd1, 4'd14, 4'd2);
    chk("down_trace_len", qlen, 15);
    chk("down_enables", en_cnt, 3);
    chk("down_decs", dec_cnt, 3);
    chk("down_counter", cnt, 14);
    chk("down_wait_min", gap_min - 2, 2);
    chk("down_wait_max", gap_max - 2, 2);

    // Bounce 3 -> 5 -> 3.
    run_dir(2'b10, 4'd3, 4'd5, 4'd0);
    chk("bounce_enables", en_cnt, 4);
    chk("bounce_decs", dec_cnt, 2);
    chk("bounce_counter", cnt, 3);
    chk("bounce_step_count", step_count, 4);
    chk("bounce_dones", done_cnt, 1);

    // Bounce with equal endpoints finishes with no steps.
    run_dir(2'b10, 4'd7, 4'd7, 4'd1);
    chk("bounce_eq_enables", en_cnt, 0);
    chk("bounce_eq_dones", done_cnt, 1);

    // Abort after the third step, start held high during the run.
    begin
      int n = 0;
      clear_mon();
      mode = 2'b00; start_value = 4'd0; target_value = 4'd10; dwell = 4'd0; start = 1'b1;
      tick();
      while (en_cnt < 3 && n < 100) begin tick(); n++; end
      if (en_cnt < 3) chk("abort_timeout", 0, 1);
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      repeat (6) tick();
      chk("abort_enables", en_cnt, 3);
      chk("abort_dones", done_cnt, 0);
      chk("abort_step_count", step_count, 3);
    end

    // Threshold at counter value 4 during a 0 -> 9 run.
    thr_en = 1'b1; thr_val = 4'd4;
    run_dir(2'b00, 4'd0, 4'd9, 4'd0);
`ifdef THRESHOLD_STOP_EN
    chk("thr_step_count", step_count, 4);
    chk("thr_hit", hit_threshold, 1);
`else
    chk("thr_step_count", step_count, 9);
    chk("thr_hit", hit_threshold, 0);
`endif
    chk("thr_dones", done_cnt, 1);
    thr_en = 1'b0;

    // Random traffic: inputs wander, start/abort at random, threshold armed at random.
    for (int i = 0; i < 4000; i++) begin
      if (q.size() == 0) begin
        mode         = 2'($urandom);
        start_value  = N'($urandom);
        target_value = N'($urandom);
        dwell        = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
        thr_en       = 1'($urandom);
        thr_val      = N'($urandom);
        start        = ($urandom_range(0, 2) == 0);
      end else begin
        start = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) begin
          mode = 2'($urandom); start_value = N'($urandom); target_value = N'($urandom);
          dwell = 4'($urandom);
        end
      end
      abort = ($urandom_range(0, 59) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; thr_en = 1'b0;
    begin
      int n = 0;
      while (q.size() != 0 && n < 600) begin tick(); n++; end
      if (q.size() != 0) chk("drain_timeout", 0, 1);
    end

    // Reset during WAIT.
    clear_mon();
    mode = 2'b00; start_value = 4'd0; target_value = 4'd5; dwell = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_enable", enable, 0);
    chk("rst_load", load, 0);
    chk("rst_done", done, 0);
    chk("rst_step_count", step_count, 0);
    chk("rst_load_ref", load_ref_value, 0);
    repeat (8) tick();
    chk("rst_dones", done_cnt, 0);
    chk("rst_enables", en_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
